// File: rtl/inst_fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned OPERAND_WIDTH     = 32;
  localparam int unsigned PC_STEP           = 4;

  localparam logic [OPERAND_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Low two bits of every valid 32-bit base-ISA instruction.
  localparam logic [1:0] OPCODE_VALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // Force a byte address onto a word boundary.
  function automatic logic [OPERAND_WIDTH-1:0] align_word(input logic [OPERAND_WIDTH-1:0] addr);
    return {addr[OPERAND_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: issues word fetches, holds the returned
// instruction until decode consumes it, and handles branch redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC          = inst_fetch_pkg::RESET_PC_DEFAULT,
  parameter int unsigned INSTRUCTION_WIDTH = inst_fetch_pkg::INSTRUCTION_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_rvalid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  input  logic                         stall_in,
  output logic [INSTRUCTION_WIDTH-1:0] inst,
  output logic [31:0]                  inst_pc,
  output logic                         inst_valid,
  output logic                         inst_illegal,
  output logic                         fetch_misaligned
);

  import inst_fetch_pkg::*;

  localparam int unsigned AW = OPERAND_WIDTH;

  fetch_state_t                 state;
  fetch_state_t                 state_next;
  logic [AW-1:0]                pc;
  logic [AW-1:0]                pc_next;
  logic                         kill;
  logic                         kill_next;
  logic [INSTRUCTION_WIDTH-1:0] inst_next;
  logic [AW-1:0]                inst_pc_next;
  logic                         inst_valid_next;
  logic                         imem_req_next;
  logic [AW-1:0]                imem_addr_next;
  logic                         misaligned_next;
  logic [AW-1:0]                redirect_target;

  assign redirect_target = align_word(redirect_pc);

  // Next-state, PC, kill and instruction-buffer logic.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    kill_next       = kill;
    inst_next       = inst;
    inst_pc_next    = inst_pc;
    inst_valid_next = inst_valid;
    misaligned_next = redirect_valid && (redirect_pc[1:0] != 2'b00);

    unique case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
        if (redirect_valid) begin
          pc_next = redirect_target;
        end
      end

      ST_REQ: begin
        // The request already left with the old PC; its data must be dropped.
        state_next = ST_WAIT;
        if (redirect_valid) begin
          pc_next   = redirect_target;
          kill_next = 1'b1;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid || kill) begin
            // Response belongs to a squashed path; refetch from the current PC.
            if (redirect_valid) begin
              pc_next = redirect_target;
            end
            kill_next  = 1'b0;
            state_next = ST_REQ;
          end else begin
            inst_next       = imem_rdata;
            inst_pc_next    = pc;
            inst_valid_next = 1'b1;
            pc_next         = pc + AW'(PC_STEP);
            state_next      = ST_HOLD;
          end
        end else if (redirect_valid) begin
          pc_next   = redirect_target;
          kill_next = 1'b1;
        end
      end

      ST_HOLD: begin
        // Redirect wins over stall and over a normal consume.
        if (redirect_valid) begin
          inst_valid_next = 1'b0;
          pc_next         = redirect_target;
          state_next      = ST_REQ;
        end else if (!stall_in) begin
          inst_valid_next = 1'b0;
          state_next      = ST_REQ;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    imem_req_next  = (state_next == ST_REQ);
    imem_addr_next = imem_req_next ? pc_next : imem_addr;
  end

  // State, PC and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      pc               <= RESET_PC;
      kill             <= 1'b0;
      inst             <= '0;
      inst_pc          <= '0;
      inst_valid       <= 1'b0;
      imem_req         <= 1'b0;
      imem_addr        <= '0;
      fetch_misaligned <= 1'b0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      kill             <= kill_next;
      inst             <= inst_next;
      inst_pc          <= inst_pc_next;
      inst_valid       <= inst_valid_next;
      imem_req         <= imem_req_next;
      imem_addr        <= imem_addr_next;
      fetch_misaligned <= misaligned_next;
    end
  end

  // Illegal flag is decoded straight from the held instruction.
  assign inst_illegal = inst_valid && (inst[1:0] != OPCODE_VALID);

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch with a transaction-level reference model
// and a variable-latency instruction memory.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NCYC     = 4000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_in;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_illegal;
  logic        fetch_misaligned;

  inst_fetch #(
    .RESET_PC          (RESET_PC),
    .INSTRUCTION_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .stall_in         (stall_in),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .inst_valid       (inst_valid),
    .inst_illegal     (inst_illegal),
    .fetch_misaligned (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage has promised to the outside world.
  logic [31:0] m_pc;        // next address to fetch
  logic        m_req;       // a fetch request is on the bus this cycle
  logic [31:0] m_addr;
  logic        m_busy;      // request issued, response not yet seen
  logic        m_kill;      // outstanding response belongs to a dead path
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_inst_pc;
  logic        m_mis;

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_req     = 1'b0;
    m_addr    = 32'h0;
    m_busy    = 1'b0;
    m_kill    = 1'b0;
    m_valid   = 1'b0;
    m_inst    = 32'h0;
    m_inst_pc = 32'h0;
    m_mis     = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rd, input logic rdr,
                            input logic [31:0] rpc, input logic st);
    logic [31:0] tgt;
    logic [31:0] n_pc;
    logic        n_busy;
    logic        n_kill;
    logic        n_valid;
    logic [31:0] n_inst;
    logic [31:0] n_ipc;
    logic        issue;
    tgt     = rpc & 32'hFFFF_FFFC;
    n_pc    = m_pc;
    n_busy  = m_busy;
    n_kill  = m_kill;
    n_valid = m_valid;
    n_inst  = m_inst;
    n_ipc   = m_inst_pc;
    issue   = 1'b0;
    if (m_req) begin
      n_busy = 1'b1;
      if (rdr) begin
        n_pc   = tgt;
        n_kill = 1'b1;
      end
    end else if (m_busy) begin
      if (rv) begin
        n_busy = 1'b0;
        if (rdr || m_kill) begin
          if (rdr) n_pc = tgt;
          n_kill = 1'b0;
          issue  = 1'b1;
        end else begin
          n_inst  = rd;
          n_ipc   = m_pc;
          n_valid = 1'b1;
          n_pc    = m_pc + 32'd4;
        end
      end else if (rdr) begin
        n_pc   = tgt;
        n_kill = 1'b1;
      end
    end else if (m_valid) begin
      if (rdr || !st) begin
        n_valid = 1'b0;
        issue   = 1'b1;
        if (rdr) n_pc = tgt;
      end
    end else begin
      issue = 1'b1;
      if (rdr) n_pc = tgt;
    end
    m_mis     = rdr && (rpc[1:0] != 2'b00);
    m_req     = issue;
    if (issue) m_addr = n_pc;
    m_pc      = n_pc;
    m_busy    = n_busy;
    m_kill    = n_kill;
    m_valid   = n_valid;
    m_inst    = n_inst;
    m_inst_pc = n_ipc;
  endtask

  task automatic compare_outputs();
    check("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check("imem_addr", imem_addr, m_addr);
    check("inst_valid", 32'(inst_valid), 32'(m_valid));
    if (m_valid) begin
      check("inst", inst, m_inst);
      check("inst_pc", inst_pc, m_inst_pc);
    end
    check("inst_illegal", 32'(inst_illegal), 32'(m_valid && (m_inst[1:0] != 2'b11)));
    check("fetch_misaligned", 32'(fetch_misaligned), 32'(m_mis));
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_illegal", 32'(inst_illegal), 32'h0);
    check("rst_misaligned", 32'(fetch_misaligned), 32'h0);
  endtask

  logic [31:0] targets [6];
  int          mem_cnt;

  function automatic logic [31:0] pick_rdata();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) return 32'h0000_0000;
    if (sel == 1) return 32'h0000_0013;
    if (sel < 6)  return $urandom | 32'h3;
    return $urandom;
  endfunction

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    mem_cnt        = 0;
    targets[0]     = 32'h0000_0100;
    targets[1]     = 32'h0000_0202;
    targets[2]     = 32'hFFFF_FFF8;
    targets[3]     = 32'hFFFF_FFFE;
    targets[4]     = 32'h0000_0000;
    targets[5]     = 32'h0000_0041;
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall_in       = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      compare_outputs();

      // Memory: one response per request after 1..3 cycles, plus stray
      // responses while nothing is outstanding.
      imem_rvalid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        imem_rvalid = (mem_cnt == 0);
      end else if (!m_busy) begin
        imem_rvalid = ($urandom_range(0, 15) == 0);
      end
      if (imem_req) mem_cnt = int'($urandom_range(1, 3));
      imem_rdata = pick_rdata();

      redirect_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = $urandom;
      else redirect_pc = targets[$urandom_range(0, 5)];
      stall_in = ($urandom_range(0, 9) < 4);

      model_step(imem_rvalid, imem_rdata, redirect_valid, redirect_pc, stall_in);

      @(negedge clk);

      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        mem_cnt        = 0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        stall_in       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
